// File: rtl/gray_bin_conv_pipe.sv
// gray_bin_conv_pipe: pipelined Gray/binary converter with per-word mode.
// Valid/ready on both sides; empty slots collapse while the output stalls.
`timescale 1ns/1ps
module gray_bin_conv_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_mode,
    output logic [WIDTH-1:0] out_data
);

    localparam int CH = (WIDTH + STAGES - 1) / STAGES;

    logic [STAGES-1:0]            v;
    logic [STAGES-1:0]            m;
    logic [STAGES-1:0][WIDTH-1:0] d;
    logic [STAGES-1:0]            adv;
    logic [STAGES-1:0][WIDTH-1:0] nd;

    // Stage k resolves the Gray bits of chunk k (MSB first); bits above
    // are already binary, bits below are still raw Gray.
    // Binary-to-Gray needs no carry and is done entirely in stage 0.
    function automatic logic [WIDTH-1:0] step(
        input int               k,
        input logic             md,
        input logic [WIDTH-1:0] x
    );
        logic [WIDTH-1:0] r;
        r = x;
        if (md) begin
            if (k == 0) r = x ^ (x >> 1);
        end else begin
            for (int i = WIDTH - 2; i >= 0; i--) begin
                if ((WIDTH - 1 - i) / CH == k) r[i] = r[i+1] ^ x[i];
            end
        end
        return r;
    endfunction

    // Advance chain: a slot may move when it is empty or its successor moves.
    always_comb begin
        logic a;
        adv = '0;
        a = !v[STAGES-1] | out_ready;
        adv[STAGES-1] = a;
        for (int k = STAGES - 2; k >= 0; k--) begin
            a = !v[k] | a;
            adv[k] = a;
        end
    end

    // Per-stage partial conversion of the word entering each slot.
    always_comb begin
        nd = '0;
        nd[0] = step(0, in_mode, in_data);
        for (int k = 1; k < STAGES; k++) begin
            nd[k] = step(k, m[k-1], d[k-1]);
        end
    end

    // Slot registers: load on advance, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            v <= '0;
            m <= '0;
            d <= '0;
        end else begin
            if (adv[0]) begin
                v[0] <= in_valid;
                if (in_valid) begin
                    m[0] <= in_mode;
                    d[0] <= nd[0];
                end
            end
            for (int k = 1; k < STAGES; k++) begin
                if (adv[k]) begin
                    v[k] <= v[k-1];
                    if (v[k-1]) begin
                        m[k] <= m[k-1];
                        d[k] <= nd[k];
                    end
                end
            end
        end
    end

    assign in_ready  = rst | adv[0];
    assign out_valid = v[STAGES-1];
    assign out_mode  = m[STAGES-1];
    assign out_data  = d[STAGES-1];

endmodule

// File: doc/gray_bin_conv_pipe.md
Name: gray_bin_conv_pipe

Overview:
- Parametrised, pipelined Gray/binary code converter; successor to the fixed 3-bit combinational converters.
- Each transfer selects its own direction: Gray-to-binary or binary-to-Gray.
- Valid/ready streaming interface on both sides, with per-stage bubble collapsing.
- Sits between counter/encoder sources (e.g. Gray-coded CDC pointers) and binary-domain consumers.

Parameters:
- WIDTH, 8, code width in bits (>= 2).
- STAGES, 2, pipeline register depth (1..WIDTH); unstalled input-to-output latency in cycles.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  input word present.
- in_ready  output  1  converter accepts input this cycle.
- in_mode  input  1  0 = Gray-to-binary, 1 = binary-to-Gray.
- in_data  input  WIDTH  word to convert.
- out_valid  output  1  converted word present.
- out_ready  input  1  downstream accepts output this cycle.
- out_mode  output  1  mode of the word on out_data (echo of in_mode).
- out_data  output  WIDTH  converted word.

Behaviour:
- Function, Gray-to-binary: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] ^ g[i]. This is a prefix XOR from the MSB.
- Function, binary-to-Gray: g = b ^ (b >> 1).
- Partitioning across stages: the prefix XOR may be split over stages in any way (e.g. ceil(WIDTH/STAGES) bits per stage). Only the output value and timing below are normative.
- Pipeline state: STAGES slots, each holding a valid bit v[k], mode and partial data. Slot STAGES-1 drives out_valid, out_mode and out_data.
- Advance rule:
  - adv[STAGES-1] = !v[STAGES-1] | out_ready.
  - adv[k] = !v[k] | adv[k+1].
  - in_ready = adv[0].
  - in_ready is combinational from out_ready and registered valids only; it never depends on in_valid.
- Input transfer: occurs when in_valid & in_ready. Slot 0 loads, v[0] <= 1. If adv[0] and no transfer, v[0] <= 0.
- Slot shift: slot k loads from k-1 when adv[k]. v[k] <= v[k-1] when adv[k], otherwise it holds.
- Latency: a word accepted in cycle N appears on out_data in cycle N+STAGES when no stall occurs. Full throughput is 1 word/cycle.
- Ordering: words exit strictly in acceptance order. No drop, no duplication.
- Mode independence: a stream may mix modes on consecutive cycles; each word is converted by its own mode bit.
- Stall: while out_valid & !out_ready, out_data and out_mode hold stable. Upstream bubbles collapse: an empty slot still accepts a word even though the output is stalled.
- Full: when all STAGES slots are valid and out_ready = 0, in_ready = 0.
- Simultaneous events: when full and out_ready = 1, the output transfer and the input acceptance happen in the same cycle; occupancy stays unchanged.
- Reset:
  - While rst = 1: all v[k] = 0, out_valid = 0, out_data = 0, out_mode = 0.
  - in_ready = 1 during reset, but no input is captured while rst = 1.
  - Reset mid-stream discards all in-flight words. The first word accepted after rst falls emerges STAGES cycles later.
- out_data/out_mode values while out_valid = 0 are don't-care except directly after reset (0).

Test Plan:
- WIDTH=3, STAGES=1, mode 0, feed Gray 000..111 back-to-back with out_ready=1 -> out_data 000,001,011,010,111,110,100,101. Each output arrives one cycle after its input.
- WIDTH=8, STAGES=2, inputs 8'hFF mode 0 then 8'hAA mode 1 -> outputs 8'hAA (out_mode 0) then 8'hFF (out_mode 1), in cycles N+2 and N+3.
- WIDTH=8, STAGES=2, out_ready=0 for 5 cycles with continuous in_valid -> in_ready drops after exactly 2 accepts and out_data holds stable. Releasing out_ready drains the words in order with no loss.
- Full pipeline, out_ready=1, in_valid=1 -> one word in and one word out per cycle, with in_ready continuously 1.
- Assert rst for 1 cycle with 2 words in flight -> out_valid=0 and out_data=0 next cycle, and the in-flight words never appear. A word sent right after reset (8'h01, mode 1) exits as 8'h01 two cycles later.
- Randomised mode/data/backpressure, 10k words, WIDTH=16, STAGES=4 -> scoreboard matches the reference function and order exactly.
